spr_diff_window: RTL and testbench



---
 rtl/spr_diff_window.sv | 89 ++++++++
 tb/tb_spr_diff_window.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spr_diff_window.sv
// spr_diff_window: 3-tap line window emitting signed centre-previous and centre-next pixel differences.
// Ports: clk, rst_n (synchronous, active-low); in_valid/in_ready/in_pix/in_sol/in_eol is the input pixel
//   stream; out_valid/out_ready/out_pix/curr_prev_diff/curr_next_diff/out_sol/out_eol is the registered
//   window sample; line_err pulses one cycle after a protocol violation is accepted.
// Define SPR_EDGE_ZERO_EN to zero-pad missing edge neighbours; by default they are replicated.
module spr_diff_window #(
    parameter int PIX_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_sol,
    input  logic             in_eol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic [PIX_W:0]   curr_prev_diff,
    output logic [PIX_W:0]   curr_next_diff,
    output logic             out_sol,
    output logic             out_eol,
    output logic             line_err
);
    localparam logic [1:0] IDLE = 2'd0, ACTIVE = 2'd1, FLUSH = 2'd2;

    logic [1:0]       state;
    logic [PIX_W-1:0] prev_r, curr_r, next_pix, edge_start, edge_end;
    logic             first_r, slot_free, acc, start, emit, flush_go;

`ifdef SPR_EDGE_ZERO_EN
    assign edge_start = '0;
    assign edge_end   = '0;
`else
    assign edge_start = in_pix;
    assign edge_end   = curr_r;
`endif

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state != FLUSH) && slot_free;
    assign acc       = in_valid && in_ready;
    // A sol pixel always starts a fresh line, discarding any held window.
    assign start     = acc && in_sol;
    assign flush_go  = (state == FLUSH) && slot_free;
    assign emit      = (acc && !in_sol && state == ACTIVE) || flush_go;
    // Flush has no incoming neighbour, so the right edge substitutes for it.
    assign next_pix  = flush_go ? edge_end : in_pix;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            prev_r         <= '0;
            curr_r         <= '0;
            first_r        <= 1'b0;
            out_valid      <= 1'b0;
            out_pix        <= '0;
            curr_prev_diff <= '0;
            curr_next_diff <= '0;
            out_sol        <= 1'b0;
            out_eol        <= 1'b0;
            line_err       <= 1'b0;
        end else begin
            line_err <= acc && (in_sol ? state == ACTIVE : state == IDLE);
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (emit) begin
                out_valid      <= 1'b1;
                out_pix        <= curr_r;
                curr_prev_diff <= {1'b0, curr_r} - {1'b0, prev_r};
                curr_next_diff <= {1'b0, curr_r} - {1'b0, next_pix};
                out_sol        <= first_r;
                out_eol        <= flush_go;
            end
            if (start) begin
                curr_r  <= in_pix;
                prev_r  <= edge_start;
                first_r <= 1'b1;
                state   <= in_eol ? FLUSH : ACTIVE;
            end else if (emit && !flush_go) begin
                prev_r  <= curr_r;
                curr_r  <= in_pix;
                first_r <= 1'b0;
                state   <= in_eol ? FLUSH : ACTIVE;
            end else if (flush_go) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_spr_diff_window.sv
// tb_spr_diff_window: directed and random stream checks of spr_diff_window against a line-level model.
module tb_spr_diff_window;
    localparam int W = 12;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_sol = 1'b0, in_eol = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_pix = '0;
    logic in_ready, out_valid, out_sol, out_eol, line_err;
    logic [W-1:0] out_pix;
    logic [W:0] curr_prev_diff, curr_next_diff;

    typedef struct { int pix; int dp; int dn; bit sol; bit eol; } samp_t;
    typedef struct { int pix; bit sol; bit eol; } item_t;

    samp_t exp_q[$];
    item_t stim[$];
    int    ln[$];
    int    vectors = 0, errors = 0;
    bit    err_exp = 1'b0, stalled = 1'b0, acc_s = 1'b0;
    logic  ir_s;
    logic [W-1:0] h_pix;
    logic [W:0]   h_dp, h_dn;
    logic         h_sol, h_eol;

    always #5 clk = ~clk;

    spr_diff_window #(.PIX_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix), .in_sol(in_sol), .in_eol(in_eol),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
        .curr_prev_diff(curr_prev_diff), .curr_next_diff(curr_next_diff),
        .out_sol(out_sol), .out_eol(out_eol), .line_err(line_err)
    );

    function automatic int edge_of(int c);
`ifdef SPR_EDGE_ZERO_EN
        return 0;
`else
        return c;
`endif
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] want);
        vectors++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic void push(int c, int p, int n, bit s, bit e);
        exp_q.push_back('{c, c - p, c - n, s, e});
    endfunction

    // Line-level reference: a pixel's sample is known once its right neighbour arrives or the line ends.
    function automatic void model(int pix, bit sol, bit eol);
        int k;
        err_exp = 1'b0;
        if (sol) begin
            err_exp = ln.size() > 0;
            ln = {pix};
        end else if (ln.size() == 0) begin
            err_exp = 1'b1;
            return;
        end else begin
            k = ln.size();
            push(ln[k-1], k > 1 ? ln[k-2] : edge_of(ln[k-1]), pix, k == 1, 1'b0);
            ln.push_back(pix);
        end
        if (eol) begin
            k = ln.size();
            push(ln[k-1], k > 1 ? ln[k-2] : edge_of(ln[k-1]), edge_of(ln[k-1]), k == 1, 1'b1);
            ln.delete();
        end
    endfunction

    task automatic cycle(input bit v, input int pix, input bit sol, input bit eol, input bit rdy);
        samp_t e;
        in_valid = v; in_pix = W'(pix); in_sol = sol; in_eol = eol; out_ready = rdy;
        #1;
        ir_s  = in_ready;
        acc_s = 1'b0;
        if (rst_n) begin
            chk("line_err", line_err, err_exp);
            if (stalled) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_pix", out_pix, h_pix);
                chk("hold_dp", $signed(curr_prev_diff), $signed(h_dp));
                chk("hold_dn", $signed(curr_next_diff), $signed(h_dn));
                chk("hold_sol", out_sol, h_sol);
                chk("hold_eol", out_eol, h_eol);
            end
            if (out_valid && !out_ready) chk("stall_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_output", out_valid, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("out_pix", out_pix, e.pix);
                    chk("curr_prev_diff", $signed(curr_prev_diff), e.dp);
                    chk("curr_next_diff", $signed(curr_next_diff), e.dn);
                    chk("out_sol", out_sol, e.sol);
                    chk("out_eol", out_eol, e.eol);
                end
            end
            stalled = out_valid && !out_ready;
            h_pix = out_pix; h_dp = curr_prev_diff; h_dn = curr_next_diff; h_sol = out_sol; h_eol = out_eol;
            acc_s = in_valid && in_ready;
            if (acc_s) model(pix, sol, eol);
            else err_exp = 1'b0;
        end else begin
            exp_q.delete(); ln.delete(); err_exp = 1'b0; stalled = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic check_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_pix", out_pix, 0);
        chk("rst_dp", curr_prev_diff, 0);
        chk("rst_dn", curr_next_diff, 0);
        chk("rst_sol", out_sol, 0);
        chk("rst_eol", out_eol, 0);
        chk("rst_err", line_err, 0);
        chk("rst_ready", in_ready, 1);
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("drained", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        rst_n = 1'b1;
        check_reset();
        // basic line; in_ready low for exactly the one flush cycle
        cycle(1, 100, 1, 0, 1);
        cycle(1, 300, 0, 0, 1);
        cycle(1, 50, 0, 1, 1);
        cycle(0, 0, 0, 0, 1);
        chk("flush_ready", ir_s, 0);
        cycle(0, 0, 0, 0, 1);
        chk("idle_ready", ir_s, 1);
        drain();
        // single-pixel line and extremes
        cycle(1, 4095, 1, 1, 1);
        drain();
        cycle(1, 0, 1, 0, 1);
        cycle(1, 4095, 0, 1, 1);
        drain();
        // 5-cycle backpressure mid-line
        cycle(1, 10, 1, 0, 1);
        cycle(1, 20, 0, 0, 1);
        cycle(1, 30, 0, 0, 1);
        repeat (5) cycle(1, 40, 0, 0, 0);
        cycle(1, 40, 0, 0, 1);
        cycle(1, 50, 0, 1, 1);
        drain();
        // stray pixel in idle, then sol mid-line
        cycle(1, 7, 0, 0, 1);
        cycle(1, 1, 1, 0, 1);
        cycle(1, 2, 0, 0, 1);
        cycle(1, 3, 1, 0, 1);
        cycle(1, 4, 0, 0, 1);
        cycle(1, 5, 0, 1, 1);
        drain();
        // reset mid-line with a stalled output pending
        cycle(1, 11, 1, 0, 1);
        cycle(1, 12, 0, 0, 1);
        cycle(1, 13, 0, 0, 0);
        rst_n = 1'b0;
        cycle(0, 0, 0, 0, 1);
        rst_n = 1'b1;
        check_reset();
        cycle(1, 21, 1, 0, 1);
        cycle(1, 22, 0, 1, 1);
        drain();
        // random lines with random valid/ready and occasional protocol errors
        for (int l = 0; l < 40; l++) begin
            int n;
            bit trunc;
            n = $urandom_range(1, 6);
            trunc = (l != 39) && ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) stim.push_back('{int'($urandom_range(0, 4095)), 1'b0, 1'b0});
            for (int i = 0; i < n; i++)
                stim.push_back('{int'($urandom_range(0, 4095)), i == 0, !trunc && i == n - 1});
        end
        for (int c = 0; c < 3000 && stim.size() > 0; c++) begin
            bit v, r;
            v = $urandom_range(0, 3) != 0;
            r = $urandom_range(0, 3) != 0;
            cycle(v, stim[0].pix, stim[0].sol, stim[0].eol, r);
            if (acc_s) void'(stim.pop_front());
        end
        chk("stim_drained", stim.size(), 0);
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
